// File: rtl/csa_tree_pipe_pkg.sv
// Shared elaboration-time helpers for the carry-save reduction tree: row-count
// bookkeeping used to size each 3:2 layer and the pipeline depth.
package csa_tree_pipe_pkg;

  localparam int CSA_MAX_LAYERS = 16;

  function automatic int csa_next_rows(input int r);
    return 2 * (r / 3) + (r % 3);
  endfunction

  // Rows remaining after the given number of 3:2 layers.
  function automatic int csa_rows_after(input int r, input int layers);
    int n;
    n = r;
    for (int i = 0; i < CSA_MAX_LAYERS; i++) begin
      if (i < layers) begin
        n = csa_next_rows(n);
      end
    end
    return n;
  endfunction

  function automatic int csa_stages(input int r);
    int n;
    int c;
    n = 0;
    c = r;
    for (int i = 0; i < CSA_MAX_LAYERS; i++) begin
      if (c > 2) begin
        c = csa_next_rows(c);
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/csa_tree_pipe_if.sv
// Producer/consumer bundle of the CSA tree: input beat handshake plus the
// redundant Sum/Carry result handshake toward the final adder.
interface csa_tree_pipe_if #(
  parameter int ROWS  = 24,
  parameter int WIDTH = 24,
  parameter int OW    = WIDTH + $clog2(ROWS)
);
  logic                  InValid;
  logic                  InReady;
  logic [ROWS*WIDTH-1:0] OpRows;
  logic                  OutValid;
  logic                  OutReady;
  logic [OW-1:0]         Sum;
  logic [OW-1:0]         Carry;

  modport master (
    output InValid, OpRows, OutReady,
    input  InReady, OutValid, Sum, Carry
  );

  modport slave (
    input  InValid, OpRows, OutReady,
    output InReady, OutValid, Sum, Carry
  );
endinterface

// File: rtl/csa_full_adder.sv
// Single-bit full adder; the leaf cell of every 3:2 compressor row.
module csa_full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/csa_row_3to2.sv
// Vector 3:2 compressor: three OW-bit rows in, sum row and left-shifted carry
// row out, both truncated to OW bits.
module csa_row_3to2 #(
  parameter int OW = 8
) (
  input  logic [OW-1:0] a,
  input  logic [OW-1:0] b,
  input  logic [OW-1:0] c,
  output logic [OW-1:0] s,
  output logic [OW-1:0] k
);
  logic [OW-1:0] maj_s;

  for (genvar i = 0; i < OW; i++) begin : g_bit
    csa_full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .c  (c[i]),
      .s  (s[i]),
      .co (maj_s[i])
    );
  end

  // The carry out of the top bit falls off: arithmetic is modulo 2^OW.
  assign k = maj_s << 1'b1;
endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined carry-save reduction of ROWS operand rows to a Sum/Carry pair,
// one registered 3:2 layer per stage, with a global stall and synchronous flush.
module csa_tree_pipe
  import csa_tree_pipe_pkg::*;
#(
  parameter int ROWS  = 24,
  parameter int WIDTH = 24,
  parameter int OW    = WIDTH + $clog2(ROWS)
) (
  input  logic           Clk,
  input  logic           Rst_n,
  input  logic           Flush,
  csa_tree_pipe_if.slave bus
);
  localparam int STAGES = csa_stages(ROWS);

  // lvl_s[k] is the row list entering layer k; slots past the live row count are zero.
  logic [OW-1:0]     lvl_s [STAGES+1][ROWS];
  logic [STAGES-1:0] vin_s;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] v_q;
  logic              en_s;
  logic              adv_s;

  assign en_s         = ~v_q[STAGES-1] | bus.OutReady;
  assign adv_s        = en_s & ~Flush;
  assign bus.InReady  = en_s;
  assign bus.OutValid = v_q[STAGES-1];
  assign bus.Sum      = lvl_s[STAGES][0];
  assign bus.Carry    = lvl_s[STAGES][1];

  for (genvar j = 0; j < ROWS; j++) begin : g_in
    assign lvl_s[0][j] = {{(OW-WIDTH){1'b0}}, bus.OpRows[j*WIDTH +: WIDTH]};
  end

  // Flush wins over the advance so a same-cycle output/refill never happens.
  always_comb begin
    v_d = v_q;
    if (Flush) begin
      v_d = '0;
    end else if (en_s) begin
      v_d = vin_s;
    end else begin
      v_d = v_q;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_layer
    localparam int RI = csa_rows_after(ROWS, k);
    localparam int RO = csa_next_rows(RI);
    localparam int NT = RI / 3;

    logic [OW-1:0] nxt_s  [RO];
    logic [OW-1:0] data_d [RO];
    logic [OW-1:0] data_q [RO];

    if (k == 0) begin : g_head
      assign vin_s[k] = bus.InValid;
    end else begin : g_tail
      assign vin_s[k] = v_q[k-1];
    end

    for (genvar t = 0; t < NT; t++) begin : g_csa
      csa_row_3to2 #(.OW(OW)) u_csa (
        .a (lvl_s[k][3*t]),
        .b (lvl_s[k][3*t+1]),
        .c (lvl_s[k][3*t+2]),
        .s (nxt_s[2*t]),
        .k (nxt_s[2*t+1])
      );
    end

    for (genvar p = 0; p < RI - 3*NT; p++) begin : g_pass
      assign nxt_s[2*NT+p] = lvl_s[k][3*NT+p];
    end

    // Bubbles do not overwrite data, so a stage keeps its last real result.
    always_comb begin
      for (int j = 0; j < RO; j++) begin
        if (adv_s && vin_s[k]) begin
          data_d[j] = nxt_s[j];
        end else begin
          data_d[j] = data_q[j];
        end
      end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        data_q <= '{default: '0};
      end else begin
        data_q <= data_d;
      end
    end

    for (genvar j = 0; j < ROWS; j++) begin : g_out
      if (j < RO) begin : g_live
        assign lvl_s[k+1][j] = data_q[j];
      end else begin : g_zero
        assign lvl_s[k+1][j] = '0;
      end
    end
  end
endmodule

// File: tb/tb_csa_tree_pipe.sv
// Directed bench for csa_tree_pipe: a 24x24 tree and a 3x8 tree share clock,
// reset and flush; results are compared against a row-sum model.
module tb_csa_tree_pipe;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   n_chk  = 0;
  int   n_fail = 0;

  csa_tree_pipe_if #(.ROWS(24), .WIDTH(24)) bus_a ();
  csa_tree_pipe_if #(.ROWS(3),  .WIDTH(8))  bus_b ();

  csa_tree_pipe #(.ROWS(24), .WIDTH(24)) dut_a (
    .Clk(clk), .Rst_n(rst_n), .Flush(flush), .bus(bus_a)
  );
  csa_tree_pipe #(.ROWS(3), .WIDTH(8)) dut_b (
    .Clk(clk), .Rst_n(rst_n), .Flush(flush), .bus(bus_b)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [28:0] model_a(input logic [575:0] r);
    logic [28:0] acc;
    acc = '0;
    for (int i = 0; i < 24; i++) acc = acc + {5'd0, r[i*24 +: 24]};
    return acc;
  endfunction

  function automatic logic [9:0] model_b(input logic [23:0] r);
    return {2'd0, r[7:0]} + {2'd0, r[15:8]} + {2'd0, r[23:16]};
  endfunction

  function automatic logic [28:0] obs_a();
    return bus_a.Sum + bus_a.Carry;
  endfunction

  function automatic logic [9:0] obs_b();
    return bus_b.Sum + bus_b.Carry;
  endfunction

  function automatic logic [575:0] rand_rows();
    logic [575:0] r;
    for (int i = 0; i < 18; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic wait_valid_a(output int cyc);
    cyc = 1;
    while (bus_a.OutValid !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    logic [575:0] rows;
    logic [28:0]  qa[$];
    logic [9:0]   qb[$];
    logic [28:0]  hold;
    int cnt, sent, got, seen;

    rst_n = 1'b0;
    flush = 1'b0;
    bus_a.InValid = 1'b0; bus_a.OpRows = '0; bus_a.OutReady = 1'b1;
    bus_b.InValid = 1'b0; bus_b.OpRows = '0; bus_b.OutReady = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_ovalid", bus_a.OutValid, 0);
    check("rst_sum", bus_a.Sum, 0);
    check("rst_carry", bus_a.Carry, 0);
    check("rst_inready", bus_a.InReady, 1);
    check("rst_b_ovalid", bus_b.OutValid, 0);

    // All rows 24'hFFFFFF: latency and modular sum.
    bus_a.OpRows = '1; bus_a.InValid = 1'b1;
    step();
    bus_a.InValid = 1'b0;
    wait_valid_a(cnt);
    check("ff_latency", cnt, 7);
    check("ff_sum", obs_a(), 29'h17FFFFE8);
    step();
    check("ff_single", bus_a.OutValid, 0);

    // Row i = i.
    for (int i = 0; i < 24; i++) rows[i*24 +: 24] = 24'(i);
    bus_a.OpRows = rows; bus_a.InValid = 1'b1;
    step();
    bus_a.InValid = 1'b0;
    wait_valid_a(cnt);
    check("idx_latency", cnt, 7);
    check("idx_sum", obs_a(), 29'h114);
    step();

    // Ten back-to-back beats with a 3-cycle consumer stall.
    sent = 0; got = 0;
    for (int c = 0; c < 80 && got < 10; c++) begin
      bus_a.OutReady = !(c >= 9 && c < 12);
      if (sent < 10) begin
        bus_a.InValid = 1'b1;
        bus_a.OpRows  = rand_rows();
      end else begin
        bus_a.InValid = 1'b0;
      end
      #1;
      if (c >= 9 && c < 12) begin
        check("stall_inready", bus_a.InReady, 0);
        check("stall_ovalid", bus_a.OutValid, 1);
        if (c == 9) hold = obs_a();
        else check("stall_stable", obs_a(), hold);
      end
      if (bus_a.InValid && bus_a.InReady) begin
        qa.push_back(model_a(bus_a.OpRows));
        sent++;
      end
      if (bus_a.OutValid && bus_a.OutReady) begin
        check("stream_avail", 64'(qa.size() != 0), 1);
        if (qa.size() != 0) check("stream_sum", obs_a(), qa.pop_front());
        got++;
      end
      step();
    end
    bus_a.InValid = 1'b0; bus_a.OutReady = 1'b1;
    check("stream_count", got, 10);
    check("stream_drained", qa.size(), 0);
    step();
    check("stream_no_dup", bus_a.OutValid, 0);

    // Flush with four beats in flight plus one offered in the flush cycle.
    for (int i = 0; i < 4; i++) begin
      bus_a.OpRows = rand_rows(); bus_a.InValid = 1'b1;
      step();
    end
    bus_a.OpRows = rand_rows();
    flush = 1'b1;
    step();
    flush = 1'b0; bus_a.InValid = 1'b0;
    check("flush_ovalid", bus_a.OutValid, 0);
    seen = 0;
    repeat (12) begin
      step();
      if (bus_a.OutValid === 1'b1) seen++;
    end
    check("flush_leak", seen, 0);
    for (int i = 0; i < 24; i++) rows[i*24 +: 24] = 24'd1;
    bus_a.OpRows = rows; bus_a.InValid = 1'b1;
    step();
    bus_a.InValid = 1'b0;
    wait_valid_a(cnt);
    check("post_flush_latency", cnt, 7);
    check("post_flush_sum", obs_a(), 29'h18);

    // Flush together with OutReady while a result is waiting.
    bus_a.OutReady = 1'b0;
    step();
    check("hold_ovalid", bus_a.OutValid, 1);
    bus_a.OutReady = 1'b1; bus_a.InValid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; bus_a.InValid = 1'b0;
    check("flush_consume_ovalid", bus_a.OutValid, 0);
    seen = 0;
    repeat (10) begin
      step();
      if (bus_a.OutValid === 1'b1) seen++;
    end
    check("flush_consume_leak", seen, 0);

    // Asynchronous reset mid-cycle with five beats in flight.
    bus_a.OutReady = 1'b0; bus_a.OpRows = '1;
    for (int i = 0; i < 5; i++) begin
      bus_a.InValid = 1'b1;
      step();
    end
    bus_a.InValid = 1'b0;
    step();
    step();
    check("prerst_ovalid", bus_a.OutValid, 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_ovalid", bus_a.OutValid, 0);
    check("async_sum", bus_a.Sum, 0);
    check("async_carry", bus_a.Carry, 0);
    #2 rst_n = 1'b1;
    bus_a.OutReady = 1'b1;
    seen = 0;
    repeat (12) begin
      step();
      if (bus_a.OutValid === 1'b1) seen++;
    end
    check("postrst_leak", seen, 0);
    check("postrst_sum", bus_a.Sum, 0);

    // ROWS=3 tree: single-stage latency and directed sum.
    bus_b.OutReady = 1'b1;
    bus_b.OpRows = {8'h80, 8'h01, 8'hFF}; bus_b.InValid = 1'b1;
    step();
    bus_b.InValid = 1'b0;
    check("b_latency", bus_b.OutValid, 1);
    check("b_sum", obs_b(), 10'h180);
    step();
    check("b_single", bus_b.OutValid, 0);

    // ROWS=3 tree: 1000 random beats with random consumer back-pressure.
    sent = 0; got = 0;
    for (int c = 0; c < 5000 && got < 1000; c++) begin
      bus_b.OutReady = ($urandom_range(0, 3) != 0);
      if (sent < 1000) begin
        bus_b.InValid = 1'b1;
        bus_b.OpRows  = 24'($urandom);
      end else begin
        bus_b.InValid = 1'b0;
      end
      #1;
      if (bus_b.InValid && bus_b.InReady) begin
        qb.push_back(model_b(bus_b.OpRows));
        sent++;
      end
      if (bus_b.OutValid && bus_b.OutReady) begin
        check("b_avail", 64'(qb.size() != 0), 1);
        if (qb.size() != 0) check("b_rand_sum", obs_b(), qb.pop_front());
        got++;
      end
      step();
    end
    bus_b.InValid = 1'b0;
    check("b_count", got, 1000);
    check("b_drained", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
